// File: rtl/seg_pkg.sv
// seg_pkg: glyph table, blank pattern and scan FSM states shared by the seven-segment scanner
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low hex glyphs, bit order gfedcba, indexed by nibble value
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational nibble to active-low seven-segment glyph decoder
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = GLYPH[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scanner with frame-synchronous load handshake
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int DWELL     = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  lzb,
    output logic                  ready,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     anodes,
    output logic                  frame
);

    localparam int CMAX = DWELL > BLANK_CYC ? DWELL : BLANK_CYC;
    localparam int CW   = $clog2(CMAX);
    localparam int IW   = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    state_t              state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [IW-1:0]       idx, idx_nx;
    logic [4*DIGITS-1:0] disp, pend;
    logic                pend_vld;
    logic [6:0]          glyph;
    logic [DIGITS-1:0]   zero_hi;
    logic                suppress;

    // Scan state register: phase, dwell counter and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    // Next phase: BLANK for BLANK_CYC cycles, then SHOW for DWELL cycles, advancing the digit on leaving SHOW
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        if (state == ST_BLANK && cnt == BLANK_LAST) begin
            state_nx = ST_SHOW;
            cnt_nx   = '0;
        end else if (state == ST_SHOW && cnt == SHOW_LAST) begin
            state_nx = ST_BLANK;
            cnt_nx   = '0;
            idx_nx   = idx == IDX_LAST ? '0 : idx + 1'b1;
        end
    end

    hex_to_seg u_dec (
        .nib (disp[{idx, 2'b00} +: 4]),
        .seg (glyph)
    );

    // zero_hi[i] is set when digit i and every digit above it are zero
    always_comb begin : lz
        logic run;
        run     = 1'b1;
        zero_hi = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run        = run && disp[4*i +: 4] == 4'h0;
            zero_hi[i] = run;
        end
    end

    assign suppress = lzb && idx != '0 && zero_hi[idx];

    // Registered display outputs and frame pulse, all one cycle behind the scan state
    always_ff @(posedge clk) begin
        if (rst) begin
            segments <= SEG_BLANK;
            anodes   <= '1;
            frame    <= 1'b0;
        end else begin
            segments <= state == ST_SHOW && !suppress ? glyph : SEG_BLANK;
            anodes   <= state == ST_SHOW ? ~(DIGITS'(1) << idx) : '1;
            frame    <= state == ST_SHOW && cnt == SHOW_LAST && idx == IDX_LAST;
        end
    end

    // Load handshake: capture into pending while empty, commit to the display only in the frame cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            disp     <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
        end else begin
            if (frame && pend_vld) begin
                disp     <= pend;
                pend_vld <= 1'b0;
            end
            if (load && !pend_vld) begin
                pend     <= data;
                pend_vld <= 1'b1;
            end
        end
    end

    assign ready = !pend_vld;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench comparing the scanner against a frame-position reference model
module tb_seg_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int DWELL     = 4;
    localparam int BLANK_CYC = 1;
    localparam int SLOT      = BLANK_CYC + DWELL;
    localparam int FRAME_LEN = DIGITS * SLOT;

    typedef struct packed {
        logic       rdy;
        logic       frm;
        logic [3:0] an;
        logic [6:0] sg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic        lzb = 1'b0;
    logic        ready;
    logic [6:0]  segments;
    logic [3:0]  anodes;
    logic        frame;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          c = 0;
    logic [15:0] disp = '0;
    logic [15:0] pend = '0;
    bit          pv = 1'b0;

    seg_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK_CYC(BLANK_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data     (data),
        .lzb      (lzb),
        .ready    (ready),
        .segments (segments),
        .anodes   (anodes),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    function automatic bit is_frame(int cyc);
        return cyc >= FRAME_LEN && cyc % FRAME_LEN == 0;
    endfunction

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s cycle=%0d got=%b expected=%b", nm, c, act, exp);
        end
    endtask

    // Reference: output at cycle c reflects frame position (c-1) with the display held before this edge
    task automatic model_update(input logic l, input logic [15:0] d, input logic z, input logic r);
        logic [15:0] dprev, sh;
        bit          rdy_prev, frm_prev;
        int          p, dg;
        exp_t        e;
        dprev    = disp;
        rdy_prev = !pv;
        frm_prev = is_frame(c);
        if (r) begin
            c    = 0;
            disp = '0;
            pv   = 1'b0;
        end else begin
            if (frm_prev && pv) begin
                disp = pend;
                pv   = 1'b0;
            end
            if (l && rdy_prev) begin
                pend = d;
                pv   = 1'b1;
            end
            c++;
        end
        e.rdy = !pv;
        e.frm = is_frame(c);
        e.an  = 4'hF;
        e.sg  = 7'h7F;
        if (c > 0) begin
            p  = (c - 1) % FRAME_LEN;
            dg = p / SLOT;
            if (p % SLOT >= BLANK_CYC) begin
                sh    = dprev >> (4 * dg);
                e.an  = ~(4'b0001 << dg);
                e.sg  = (z && dg > 0 && sh == 16'h0) ? 7'h7F : glyph[sh[3:0]];
            end
        end
        q.push_back(e);
    endtask

    task automatic tick(input logic l, input logic [15:0] d, input logic z, input logic r);
        load = l;
        data = d;
        lzb  = z;
        rst  = r;
        @(posedge clk);
        #1;
        model_update(l, d, z, r);
    endtask

    task automatic idle(input int n, input logic z);
        repeat (n) tick(1'b0, 16'($urandom), z, 1'b0);
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s wait bound expired at cycle=%0d", nm, c);
    endtask

    // Monitor: every cycle the DUT presents a registered output word, compared against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("ready", {6'b0, ready}, {6'b0, e.rdy});
            chk("frame", {6'b0, frame}, {6'b0, e.frm});
            chk("anodes", {3'b0, anodes}, {3'b0, e.an});
            chk("segments", segments, e.sg);
        end
    end

    initial begin
        int g;
        logic z;
        repeat (3) tick(1'b0, 16'h0, 1'b0, 1'b1);
        idle(8, 1'b0);
        tick(1'b1, 16'h1A2F, 1'b0, 1'b0);
        idle(45, 1'b0);
        tick(1'b1, 16'h1234, 1'b0, 1'b0);
        idle(3, 1'b0);
        tick(1'b1, 16'hBEEF, 1'b0, 1'b0);
        idle(45, 1'b0);
        g = 0;
        while (!(pv == 1'b0 && is_frame(c)) && g < 100) begin
            idle(1, 1'b1);
            g++;
        end
        if (g >= 100) bound_fail("frame_align");
        tick(1'b1, 16'h0050, 1'b1, 1'b0);
        idle(45, 1'b1);
        tick(1'b1, 16'h0000, 1'b1, 1'b0);
        idle(25, 1'b1);
        g = 0;
        while ((c - 1) % FRAME_LEN != 2 * SLOT + 2 && g < 100) begin
            idle(1, 1'b1);
            g++;
        end
        if (g >= 100) bound_fail("digit2_align");
        tick(1'b0, 16'h0, 1'b1, 1'b1);
        idle(25, 1'b1);
        tick(1'b1, 16'h00A0, 1'b0, 1'b0);
        idle(7, 1'b0);
        tick(1'b0, 16'h0, 1'b0, 1'b1);
        idle(25, 1'b0);
        z = 1'b0;
        repeat (900) begin
            if ($urandom % 50 == 0) z = ~z;
            tick(1'($urandom % 6 == 0), 16'($urandom), z, 1'($urandom % 300 == 0));
        end
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain left=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed seven-segment digits.
REQ-002 Parameter DWELL, default 50000: clock cycles each digit is lit per frame, range 2 to 2^20.
REQ-003 Parameter BLANK_CYC, default 2: all-off cycles inserted before each digit for ghost suppression, range 1 to 255.
REQ-004 CLK  in  1  single clock; all logic on its rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 LOAD  in  1  request to load a new display value.
REQ-007 DATA  in  4*DIGITS  hex nibbles, nibble 0 (bits 3:0) is the rightmost digit.
REQ-008 LZB  in  1  live level; 1 enables leading-zero blanking.
REQ-009 READY  out  1  high when a LOAD will be accepted.
REQ-010 SEGMENTS  out  7  active-low segments, bit order gfedcba.
REQ-011 ANODES  out  DIGITS  active-low digit enables, one-hot or all-off.
REQ-012 FRAME  out  1  one-cycle pulse marking the end of a full scan frame.

Function
REQ-013 The block SHALL implement a two-state FSM: BLANK, then SHOW.
- BLANK: lasts BLANK_CYC cycles with ANODES all 1 and SEGMENTS 1111111.
- SHOW: lasts DWELL cycles with the current digit's anode low and its decoded pattern on SEGMENTS.
REQ-014 On the SHOW to BLANK transition, the digit index SHALL increment and wrap from DIGITS-1 to 0; the frame length is DIGITS*(BLANK_CYC+DWELL) cycles.
REQ-015 FRAME SHALL pulse high for exactly the last SHOW cycle of digit DIGITS-1.
REQ-016 Digit patterns SHALL be the standard active-low hex glyphs for values 0 to F.
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
REQ-017 SEGMENTS and ANODES SHALL be registered and SHALL change on the same clock edge, one cycle after the FSM state or index changes.
REQ-018 Handshake: LOAD while READY=1 SHALL capture DATA into a pending register, and READY SHALL be 0 from the next cycle.
REQ-019 LOAD while READY=0 SHALL be ignored, and the pending value SHALL be unchanged.
REQ-020 In the FRAME cycle, a valid pending value SHALL be copied into the display register, and READY SHALL return to 1 on the next cycle; displayed data therefore never changes mid-frame.
REQ-021 Simultaneous events: LOAD with READY=1 in a FRAME cycle SHALL be captured as pending and committed at the following frame end, not the current one.
REQ-022 Leading-zero blanking: with LZB=1, digit i (i>0) SHALL be shown as all-off (anode still driven) when digit i and every higher digit are 0; digit 0 is never suppressed.
REQ-023 Counters SHALL be sized by clog2 of their maximum, and SHALL have no overflow or wrap other than the digit index.

Reset
REQ-024 While RST=1 at a clock edge:
- FSM goes to BLANK; dwell counter=0; digit index=0.
- display register=0; pending register cleared.
- READY=1, SEGMENTS=1111111, ANODES all 1, FRAME=0.
REQ-025 A RST asserted mid-frame or mid-handshake SHALL discard any pending value, and the scan SHALL restart at digit 0 BLANK on the first cycle after RST deasserts.

Structure
REQ-026 The shared package seg_pkg SHALL hold the 16-entry glyph table, the SEG_BLANK constant (1111111) and the FSM state encoding.
REQ-027 Decoding SHALL be done by one combinational sub-module, hex_to_seg, which maps a 4-bit nibble to 7 segments using seg_pkg and is time-shared across all digits.

Verification (DIGITS=4, DWELL=4, BLANK_CYC=1; frame = 20 cycles)
REQ-028 Reset -> SEGMENTS=1111111, ANODES=1111, READY=1, FRAME=0; the first lit digit is ANODES=1110 showing 1000000.
REQ-029 Load DATA=16'h1A2F, LZB=0 -> after the next FRAME pulse, the following frame shows:
- F=0001110 on 1110, 2=0100100 on 1101, A=0001000 on 1011, 1=1111001 on 0111
- each digit lit 4 cycles and preceded by 1 all-off cycle; FRAME pulses every 20 cycles.
REQ-030 Load 16'h1234, then a second LOAD of 16'hBEEF while READY=0 -> the second load is ignored, the display shows 1234 after the frame end, and READY returns to 1 one cycle after FRAME.
REQ-031 LOAD 16'h0050 asserted exactly in a FRAME cycle -> not visible that frame; visible after the next FRAME. With LZB=1, digits 3 and 2 are all-off while digits 1 and 0 show 5 and 0.
REQ-032 Load DATA=16'h0000 with LZB=1 -> only digit 0 shows 1000000. Then RST asserted during SHOW of digit 2 -> outputs reach reset values next cycle, and the scan restarts at digit 0.
